// File: rtl/vote_pkg.sv
// Shared types and helpers for the ballot session controller.
//   state_e     : session FSM states
//   vote_dec_t  : classification of a valid_vote word (one-hot / multi-bit) plus encoded index
//   decode_vote : classifies and encodes a per-candidate vote word
package vote_pkg;

  localparam int unsigned NUM_CAND = 4;
  localparam int unsigned CAND_W   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCommit,
    StLockout
  } state_e;

  typedef struct packed {
    logic              one_hot;
    logic              multi;
    logic [CAND_W-1:0] idx;
  } vote_dec_t;

  // idx is only meaningful when one_hot is set.
  function automatic vote_dec_t decode_vote(input logic [NUM_CAND-1:0] v);
    vote_dec_t  d;
    logic [2:0] cnt;
    cnt   = '0;
    d.idx = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (v[i]) begin
        cnt   = cnt + 3'd1;
        d.idx = CAND_W'(i);
      end
    end
    d.one_hot = (cnt == 3'd1);
    d.multi   = (cnt >= 3'd2);
    return d;
  endfunction

endpackage

// File: rtl/vote_timer.sv
// Loadable down-counter shared by the ARMED and LOCKOUT phases.
//   clock, reset : rising-edge clock, async active-high reset (count -> 0)
//   load         : load load_value (has priority over dec)
//   dec          : decrement by one; holds at zero instead of wrapping
//   is_zero      : registered count equals zero
module vote_timer #(
  parameter int unsigned Width = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             dec,
  output logic             is_zero
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_zero = (count_q == '0);

endmodule

// File: rtl/ballot_session_ctrl.sv
// Sequences one voter session: officer start arms the machine, exactly one unambiguous vote is
// accepted and committed to the logger as a one-cycle strobe, then a fixed lockout follows.
//   clock, reset   : rising-edge clock, async active-high reset
//   mode           : 0 = vote mode, 1 = view mode (aborts an armed session)
//   voter_start    : officer start, sampled only in IDLE
//   valid_vote     : per-candidate debounced vote pulses
//   armed / busy   : ARMED, and COMMIT-or-LOCKOUT indications
//   commit_valid   : one-cycle strobe with commit_cand to the logger
//   reject         : one-cycle pulse for an ambiguous multi-bit vote while armed
//   timeout        : one-cycle pulse when an armed session is abandoned
//   voters_served  : saturating count of committed sessions
// All outputs come straight from flops; no input reaches an output combinationally.
module ballot_session_ctrl
  import vote_pkg::*;
#(
  parameter int unsigned NUM_CAND       = 4,
  parameter int unsigned CAND_W         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned LOCK_CYCLES    = 10,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                voter_start,
  input  logic [NUM_CAND-1:0] valid_vote,
  output logic                armed,
  output logic                busy,
  output logic                commit_valid,
  output logic [CAND_W-1:0]   commit_cand,
  output logic                reject,
  output logic                timeout,
  output logic [CNT_W-1:0]    voters_served
);

  localparam int unsigned TimerMax = (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax);
  localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLoad    = TimerW'(LOCK_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic              reject_q, reject_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  voters_q, voters_d;

  logic              t_load, t_dec, t_zero;
  logic [TimerW-1:0] t_value;
  vote_dec_t         vote;

  assign vote = decode_vote(valid_vote);

  vote_timer #(
    .Width(TimerW)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (t_load),
    .load_value(t_value),
    .dec       (t_dec),
    .is_zero   (t_zero)
  );

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    voters_d  = voters_q;
    t_load    = 1'b0;
    t_value   = '0;
    t_dec     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (voter_start && !mode) begin
          state_d = StArmed;
          t_load  = 1'b1;
          t_value = TimeoutLoad;
        end
      end
      StArmed: begin
        // Priority: abort, accepted vote, ambiguous vote, expiry, count down.
        if (mode) begin
          state_d = StIdle;
        end else if (vote.one_hot) begin
          cand_d  = vote.idx;
          state_d = StCommit;
        end else if (vote.multi) begin
          reject_d = 1'b1;
          t_dec    = 1'b1;
        end else if (t_zero) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          t_dec = 1'b1;
        end
      end
      StCommit: begin
        if (voters_q != '1) begin
          voters_d = voters_q + CNT_W'(1);
        end
        state_d = StLockout;
        t_load  = 1'b1;
        t_value = LockLoad;
      end
      StLockout: begin
        if (t_zero) begin
          state_d = StIdle;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cand_q    <= '0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
      voters_q  <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
      voters_q  <= voters_d;
    end
  end

  assign armed         = (state_q == StArmed);
  assign busy          = (state_q == StCommit) || (state_q == StLockout);
  assign commit_valid  = (state_q == StCommit);
  assign commit_cand   = cand_q;
  assign reject        = reject_q;
  assign timeout       = timeout_q;
  assign voters_served = voters_q;

endmodule

// File: tb/tb_ballot_session_ctrl.sv
module tb_ballot_session_ctrl;

  localparam int unsigned T     = 20;
  localparam int unsigned L     = 10;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SAT   = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             mode;
  logic             voter_start;
  logic [3:0]       valid_vote;
  logic             armed, busy, commit_valid, reject, timeout;
  logic [1:0]       commit_cand;
  logic [CNT_W-1:0] voters_served;

  ballot_session_ctrl #(
    .NUM_CAND      (4),
    .CAND_W        (2),
    .TIMEOUT_CYCLES(T),
    .LOCK_CYCLES   (L),
    .CNT_W         (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .voter_start  (voter_start),
    .valid_vote   (valid_vote),
    .armed        (armed),
    .busy         (busy),
    .commit_valid (commit_valid),
    .commit_cand  (commit_cand),
    .reject       (reject),
    .timeout      (timeout),
    .voters_served(voters_served)
  );

  always #5 clock = ~clock;

  // Cycle monitor, sampled on the falling edge.
  int         n_commit = 0, n_reject = 0, n_timeout = 0, n_armed = 0, n_busy = 0, n_overlap = 0;
  logic [1:0] last_cand = '0;

  always @(negedge clock) begin
    if (commit_valid) begin
      n_commit  <= n_commit + 1;
      last_cand <= commit_cand;
    end
    if (reject)  n_reject  <= n_reject + 1;
    if (timeout) n_timeout <= n_timeout + 1;
    if (armed)   n_armed   <= n_armed + 1;
    if (busy)    n_busy    <= n_busy + 1;
    if (commit_valid && (reject || timeout)) n_overlap <= n_overlap + 1;
  end

  int n_total = 0, n_pass = 0;
  int b_commit, b_reject, b_timeout, b_armed, b_busy;
  int model_commits = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic snap();
    b_commit  = n_commit;
    b_reject  = n_reject;
    b_timeout = n_timeout;
    b_armed   = n_armed;
    b_busy    = n_busy;
  endtask

  task automatic start_session();
    voter_start = 1'b1;
    tick(1);
    voter_start = 1'b0;
  endtask

  task automatic cast(input logic [3:0] v);
    valid_vote = v;
    tick(1);
    valid_vote = '0;
  endtask

  function automatic int sat_count(input int c);
    return (c > int'(SAT)) ? int'(SAT) : c;
  endfunction

  initial begin
    reset = 1'b1; mode = 1'b0; voter_start = 1'b0; valid_vote = '0;
    tick(2);
    check("reset_outputs", 32'({armed, busy, commit_valid, reject, timeout, commit_cand,
                                voters_served}), 32'd0);
    reset = 1'b0;
    tick(1);

    // Basic vote, then extra votes in LOCKOUT and in IDLE.
    snap();
    start_session();
    cast(4'b0100);
    tick(3);
    cast(4'b0001);
    tick(12);
    check("basic_commit_cycles", 32'(n_commit - b_commit), 32'd1);
    check("basic_cand", 32'(last_cand), 32'd2);
    check("basic_busy_cycles", 32'(n_busy - b_busy), 32'(L + 1));
    check("basic_armed_cycles", 32'(n_armed - b_armed), 32'd1);
    check("basic_idle", 32'({armed, busy}), 32'd0);
    model_commits++;
    check("basic_voters", 32'(voters_served), 32'(sat_count(model_commits)));
    cast(4'b0001);
    tick(3);
    check("double_vote_commits", 32'(n_commit - b_commit), 32'd1);
    check("double_vote_voters", 32'(voters_served), 32'(sat_count(model_commits)));

    // Ambiguous vote followed by a clean one.
    snap();
    start_session();
    cast(4'b0011);
    tick(1);
    check("ambig_reject", 32'(n_reject - b_reject), 32'd1);
    check("ambig_still_armed", 32'(armed), 32'd1);
    cast(4'b1000);
    tick(L + 4);
    check("ambig_then_commit", 32'(n_commit - b_commit), 32'd1);
    check("ambig_cand", 32'(last_cand), 32'd3);
    model_commits++;
    check("ambig_voters", 32'(voters_served), 32'(sat_count(model_commits)));

    // Timeout with no votes.
    snap();
    start_session();
    tick(T + 5);
    check("timeout_armed_cycles", 32'(n_armed - b_armed), 32'(T));
    check("timeout_pulse", 32'(n_timeout - b_timeout), 32'd1);
    check("timeout_no_commit", 32'(n_commit - b_commit), 32'd0);
    check("timeout_idle", 32'(armed), 32'd0);
    check("timeout_voters", 32'(voters_served), 32'(sat_count(model_commits)));

    // Mode abort, then start ignored in view mode.
    snap();
    start_session();
    tick(3);
    mode = 1'b1;
    tick(1);
    check("abort_armed_drop", 32'(armed), 32'd0);
    voter_start = 1'b1;
    tick(3);
    check("view_start_ignored", 32'({armed, busy}), 32'd0);
    voter_start = 1'b0;
    mode = 1'b0;
    tick(2);
    check("abort_armed_cycles", 32'(n_armed - b_armed), 32'd4);
    check("abort_no_events", 32'((n_timeout - b_timeout) + (n_commit - b_commit)
                                 + (n_reject - b_reject)), 32'd0);

    // Vote on the final armed cycle beats the timeout.
    snap();
    start_session();
    tick(T - 1);
    cast(4'b0010);
    tick(L + 4);
    check("last_cycle_commit", 32'(n_commit - b_commit), 32'd1);
    check("last_cycle_no_timeout", 32'(n_timeout - b_timeout), 32'd0);
    check("last_cycle_armed", 32'(n_armed - b_armed), 32'(T));
    check("last_cycle_cand", 32'(last_cand), 32'd1);
    model_commits++;

    // Two more sessions: five in total, counter saturates.
    for (int s = 0; s < 2; s++) begin
      start_session();
      cast(4'b0001);
      tick(L + 4);
      model_commits++;
      check("saturation_voters", 32'(voters_served), 32'(sat_count(model_commits)));
    end

    // Asynchronous reset during COMMIT.
    snap();
    start_session();
    cast(4'b0100);
    check("pre_reset_commit", 32'(commit_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("reset_in_commit", 32'({armed, busy, commit_valid, reject, timeout, commit_cand,
                                  voters_served}), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(L + 4);
    check("reset_no_commit", 32'(n_commit - b_commit), 32'd0);
    check("reset_voters", 32'(voters_served), 32'd0);
    model_commits = 0;

    // Randomized sessions against a transaction-level model.
    for (int s = 0; s < 12; s++) begin
      int unsigned k, exp_rej;
      logic [1:0]  cand;
      snap();
      exp_rej = 0;
      k = $urandom_range(0, T + 2);
      cand = 2'($urandom_range(0, 3));
      start_session();
      for (int unsigned i = 0; i < k; i++) begin
        if ((i + 1 < T) && ($urandom_range(0, 3) == 0)) begin
          int unsigned a, b;
          a = $urandom_range(0, 3);
          b = (a + 1 + $urandom_range(0, 2)) % 4;
          valid_vote = 4'((1 << a) | (1 << b));
          exp_rej++;
        end else begin
          valid_vote = '0;
        end
        tick(1);
      end
      valid_vote = '0;
      if (k < T) cast(4'(1 << cand));
      tick(L + 4);
      if (k < T) begin
        model_commits++;
        check("rand_commit", 32'(n_commit - b_commit), 32'd1);
        check("rand_cand", 32'(last_cand), 32'(cand));
        check("rand_armed", 32'(n_armed - b_armed), 32'(k + 1));
        check("rand_no_timeout", 32'(n_timeout - b_timeout), 32'd0);
      end else begin
        check("rand_no_commit", 32'(n_commit - b_commit), 32'd0);
        check("rand_timeout", 32'(n_timeout - b_timeout), 32'd1);
        check("rand_armed", 32'(n_armed - b_armed), 32'(T));
      end
      check("rand_reject", 32'(n_reject - b_reject), 32'(exp_rej));
      check("rand_voters", 32'(voters_served), 32'(sat_count(model_commits)));
    end

    check("no_overlap", 32'(n_overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
